// File: rtl/preparador_datos_seg.sv
// preparador_datos_seg
//   Decodes one instruction per cycle into register addresses, use/write
//   flags, ALU B-operand select and sign-extended immediate. A scoreboard of
//   in-flight register writes stalls instructions that read or overwrite a
//   pending register. Results leave through a one-entry valid/ready stage.
//   XLEN must be at least 32.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_inst_valid/o_in_ready instruction handshake (accept = valid && ready)
//   i_inst, i_type          instruction word and format (000 I .. 101 U)
//   i_wb_valid, i_wb_addr   writeback completing this cycle
//   o_out_valid/i_out_ready result handshake
//   o_a1,o_a2,o_a3          rs1, rs2, rd (0 when unused)
//   o_use_a1,o_use_a2,o_we  rs1 read, rs2 read, rd written
//   o_sel                   1 = ALU B from immediate
//   o_imm                   sign-extended immediate
//   o_illegal               type 110/111
module preparador_datos_seg #(
   parameter int unsigned XLEN          = 32,
   parameter bit          SCOREBOARD_EN = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_inst_valid,
   output logic            o_in_ready,
   input  logic [31:0]     i_inst,
   input  logic [2:0]      i_type,
   input  logic            i_wb_valid,
   input  logic [4:0]      i_wb_addr,
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [4:0]      o_a1,
   output logic [4:0]      o_a2,
   output logic [4:0]      o_a3,
   output logic            o_use_a1,
   output logic            o_use_a2,
   output logic            o_we,
   output logic            o_sel,
   output logic [XLEN-1:0] o_imm,
   output logic            o_illegal
);

   typedef enum logic [2:0] {
      T_I = 3'b000,
      T_S = 3'b001,
      T_R = 3'b010,
      T_B = 3'b011,
      T_J = 3'b100,
      T_U = 3'b101
   } inst_type_e;

   typedef struct packed {
      logic [4:0]      a1;
      logic [4:0]      a2;
      logic [4:0]      a3;
      logic            use_a1;
      logic            use_a2;
      logic            we;
      logic            sel;
      logic            illegal;
      logic [XLEN-1:0] imm;
   } res_t;

   res_t        w_dec;
   res_t        r_res;
   logic        r_out_valid;
   logic [31:0] r_pend;
   logic [31:0] w_effpend;
   logic [31:0] w_pend_nxt;
   logic        w_hazard;
   logic        w_accept;

   // Field extraction and immediate generation
   always_comb begin
      w_dec = '0;
      unique case (inst_type_e'(i_type))
         T_I: begin
            w_dec.a1     = i_inst[19:15];
            w_dec.a3     = i_inst[11:7];
            w_dec.use_a1 = 1'b1;
            w_dec.we     = 1'b1;
            w_dec.sel    = 1'b1;
            w_dec.imm    = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
         end
         T_S: begin
            w_dec.a1     = i_inst[19:15];
            w_dec.a2     = i_inst[24:20];
            w_dec.use_a1 = 1'b1;
            w_dec.use_a2 = 1'b1;
            w_dec.sel    = 1'b1;
            w_dec.imm    = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         end
         T_R: begin
            w_dec.a1     = i_inst[19:15];
            w_dec.a2     = i_inst[24:20];
            w_dec.a3     = i_inst[11:7];
            w_dec.use_a1 = 1'b1;
            w_dec.use_a2 = 1'b1;
            w_dec.we     = 1'b1;
         end
         T_B: begin
            w_dec.a1     = i_inst[19:15];
            w_dec.a2     = i_inst[24:20];
            w_dec.use_a1 = 1'b1;
            w_dec.use_a2 = 1'b1;
            w_dec.sel    = 1'b1;
            w_dec.imm    = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7],
                            i_inst[30:25], i_inst[11:8], 1'b0};
         end
         T_J: begin
            w_dec.a3     = i_inst[11:7];
            w_dec.we     = 1'b1;
            w_dec.sel    = 1'b1;
            w_dec.imm    = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12],
                            i_inst[20], i_inst[30:21], 1'b0};
         end
         T_U: begin
            w_dec.a3     = i_inst[11:7];
            w_dec.we     = 1'b1;
            w_dec.sel    = 1'b1;
            // Extend the 20-bit field first, then shift, so XLEN=32 needs no
            // zero-width replication.
            w_dec.imm    = {{(XLEN-20){i_inst[31]}}, i_inst[31:12]} << 12;
         end
         default: w_dec.illegal = 1'b1;
      endcase
      // x0 writes are discarded, so they must never mark x0 as pending
      if (w_dec.a3 == 5'd0) w_dec.we = 1'b0;
   end

   // Scoreboard: a writeback clear is visible to the hazard check this cycle
   always_comb begin
      w_effpend = r_pend;
      if (i_wb_valid) w_effpend[i_wb_addr] = 1'b0;
   end

   assign w_hazard = SCOREBOARD_EN && i_inst_valid &&
                     ((w_dec.use_a1 && w_effpend[w_dec.a1]) ||
                      (w_dec.use_a2 && w_effpend[w_dec.a2]) ||
                      (w_dec.we     && w_effpend[w_dec.a3]));

   assign o_in_ready = (!r_out_valid || i_out_ready) && !w_hazard;
   assign w_accept   = i_inst_valid && o_in_ready;

   // Set applied after the clear so a same-cycle set of the same register wins
   always_comb begin
      w_pend_nxt = w_effpend;
      if (w_accept && w_dec.we) w_pend_nxt[w_dec.a3] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pend      <= '0;
         r_out_valid <= 1'b0;
         r_res       <= '0;
      end else begin
         if (SCOREBOARD_EN) r_pend <= w_pend_nxt;
         if (w_accept) begin
            r_res       <= w_dec;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_a1        = r_res.a1;
   assign o_a2        = r_res.a2;
   assign o_a3        = r_res.a3;
   assign o_use_a1    = r_res.use_a1;
   assign o_use_a2    = r_res.use_a2;
   assign o_we        = r_res.we;
   assign o_sel       = r_res.sel;
   assign o_imm       = r_res.imm;
   assign o_illegal   = r_res.illegal;

endmodule

// File: tb/tb_preparador_datos_seg.sv
module tb_preparador_datos_seg;

   logic        clk = 1'b0;
   logic        reset, inst_valid, wb_valid, out_ready;
   logic [31:0] inst;
   logic [2:0]  typ;
   logic [4:0]  wb_addr;

   logic        in_ready, out_valid, use_a1, use_a2, we, sel, illegal;
   logic [4:0]  a1, a2, a3;
   logic [31:0] imm;

   logic        ns_in_ready, ns_out_valid, ns_use_a1, ns_use_a2, ns_we, ns_sel, ns_illegal;
   logic [4:0]  ns_a1, ns_a2, ns_a3;
   logic [31:0] ns_imm;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   preparador_datos_seg #(.XLEN(32), .SCOREBOARD_EN(1'b1)) dut (
      .i_clk(clk), .i_reset(reset), .i_inst_valid(inst_valid), .o_in_ready(in_ready),
      .i_inst(inst), .i_type(typ), .i_wb_valid(wb_valid), .i_wb_addr(wb_addr),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_a1(a1), .o_a2(a2), .o_a3(a3), .o_use_a1(use_a1), .o_use_a2(use_a2),
      .o_we(we), .o_sel(sel), .o_imm(imm), .o_illegal(illegal));

   preparador_datos_seg #(.XLEN(32), .SCOREBOARD_EN(1'b0)) dut_ns (
      .i_clk(clk), .i_reset(reset), .i_inst_valid(inst_valid), .o_in_ready(ns_in_ready),
      .i_inst(inst), .i_type(typ), .i_wb_valid(wb_valid), .i_wb_addr(wb_addr),
      .o_out_valid(ns_out_valid), .i_out_ready(out_ready),
      .o_a1(ns_a1), .o_a2(ns_a2), .o_a3(ns_a3), .o_use_a1(ns_use_a1), .o_use_a2(ns_use_a2),
      .o_we(ns_we), .o_sel(ns_sel), .o_imm(ns_imm), .o_illegal(ns_illegal));

   typedef struct packed {
      logic [4:0]  a1, a2, a3;
      logic        u1, u2, we, sel, ill;
      logic [31:0] imm;
   } dec_t;

   // Reference state for the scoreboard-enabled instance
   bit [31:0] m_pend;
   bit        m_ov;
   dec_t      m_out;
   bit        m_known = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Immediates built by plain two's-complement arithmetic on the raw field
   function automatic dec_t decode(input logic [2:0] t, input logic [31:0] i);
      dec_t d;
      int   v;
      d = '0;
      v = 0;
      case (t)
         3'd0: begin
            d.a1 = i[19:15]; d.a3 = i[11:7]; d.u1 = 1; d.we = 1; d.sel = 1;
            v = int'(i[31:20]) - (i[31] ? 4096 : 0);
         end
         3'd1: begin
            d.a1 = i[19:15]; d.a2 = i[24:20]; d.u1 = 1; d.u2 = 1; d.sel = 1;
            v = int'({i[31:25], i[11:7]}) - (i[31] ? 4096 : 0);
         end
         3'd2: begin
            d.a1 = i[19:15]; d.a2 = i[24:20]; d.a3 = i[11:7];
            d.u1 = 1; d.u2 = 1; d.we = 1;
         end
         3'd3: begin
            d.a1 = i[19:15]; d.a2 = i[24:20]; d.u1 = 1; d.u2 = 1; d.sel = 1;
            v = int'({i[31], i[7], i[30:25], i[11:8], 1'b0}) - (i[31] ? 8192 : 0);
         end
         3'd4: begin
            d.a3 = i[11:7]; d.we = 1; d.sel = 1;
            v = int'({i[31], i[19:12], i[20], i[30:21], 1'b0}) - (i[31] ? 2097152 : 0);
         end
         3'd5: begin
            d.a3 = i[11:7]; d.we = 1; d.sel = 1;
            v = int'(i & 32'hFFFF_F000);
         end
         default: d.ill = 1;
      endcase
      d.imm = 32'(v);
      if (d.a3 == 5'd0) d.we = 0;
      return d;
   endfunction

   // One cycle: compare at the falling edge, advance the model, return at posedge+1
   task automatic step();
      dec_t      d;
      bit [31:0] eff;
      bit        haz, rdy, acc;
      @(negedge clk);
      d   = decode(typ, inst);
      eff = m_pend;
      if (wb_valid) eff[wb_addr] = 1'b0;
      haz = inst_valid && ((d.u1 && eff[d.a1]) || (d.u2 && eff[d.a2]) || (d.we && eff[d.a3]));
      rdy = (!m_ov || out_ready) && !haz;
      if (m_known) begin
         if (!reset) chk("in_ready", 32'(in_ready), 32'(rdy));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         if (m_ov) begin
            chk("a1", 32'(a1), 32'(m_out.a1));
            chk("a2", 32'(a2), 32'(m_out.a2));
            chk("a3", 32'(a3), 32'(m_out.a3));
            chk("use_a1", 32'(use_a1), 32'(m_out.u1));
            chk("use_a2", 32'(use_a2), 32'(m_out.u2));
            chk("we", 32'(we), 32'(m_out.we));
            chk("sel", 32'(sel), 32'(m_out.sel));
            chk("illegal", 32'(illegal), 32'(m_out.ill));
            chk("imm", imm, m_out.imm);
         end
      end
      if (reset) begin
         m_pend  = '0;
         m_ov    = 0;
         m_out   = '0;
         m_known = 1'b1;
      end else begin
         acc    = inst_valid && rdy;
         m_pend = eff;
         if (acc && d.we) m_pend[d.a3] = 1'b1;
         if (acc) begin
            m_out = d;
            m_ov  = 1;
         end else if (m_ov && out_ready) begin
            m_ov = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1; inst_valid = 0; wb_valid = 0; wb_addr = 0; out_ready = 1;
      inst = 0; typ = 0;
      step(); step();
      reset = 0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_imm", imm, 32'd0);
      chk("rst_a3", 32'(a3), 32'd0);

      // addi x5,x1,7
      typ = 3'd0; inst = 32'h0070_8293; inst_valid = 1;
      #1 chk("addi_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("addi_ov", 32'(out_valid), 32'd1);
      chk("addi_a1", 32'(a1), 32'd1);
      chk("addi_a2", 32'(a2), 32'd0);
      chk("addi_a3", 32'(a3), 32'd5);
      chk("addi_we", 32'(we), 32'd1);
      chk("addi_sel", 32'(sel), 32'd1);
      chk("addi_imm", imm, 32'h0000_0007);

      // add x6,x5,x2 stalls on pending x5 until its writeback
      typ = 3'd2; inst = 32'h0022_8333;
      #1 chk("add_stall0", 32'(in_ready), 32'd0);
      step(); step();
      chk("add_stall2", 32'(in_ready), 32'd0);
      wb_valid = 1; wb_addr = 5'd5;
      #1 chk("add_wb_ready", 32'(in_ready), 32'd1);
      step();
      wb_valid = 0;
      chk("add_a1", 32'(a1), 32'd5);
      chk("add_a2", 32'(a2), 32'd2);
      chk("add_a3", 32'(a3), 32'd6);
      chk("add_sel", 32'(sel), 32'd0);

      // sw x2,-4(x1)
      typ = 3'd1; inst = 32'hFE20_AE23;
      step();
      chk("sw_a1", 32'(a1), 32'd1);
      chk("sw_a2", 32'(a2), 32'd2);
      chk("sw_we", 32'(we), 32'd0);
      chk("sw_imm", imm, 32'hFFFF_FFFC);

      // lui x3,0x12345 then hold with out_ready low
      typ = 3'd5; inst = 32'h1234_51B7;
      step();
      typ = 3'd6; inst = 32'hFFFF_FFFF; out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("hold_in_ready", 32'(in_ready), 32'd0);
         step();
         chk("lui_ov", 32'(out_valid), 32'd1);
         chk("lui_imm", imm, 32'h1234_5000);
         chk("lui_a3", 32'(a3), 32'd3);
      end
      out_ready = 1;
      #1 chk("ill_ready", 32'(in_ready), 32'd1);
      step();
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_a1", 32'(a1), 32'd0);
      chk("ill_a3", 32'(a3), 32'd0);
      chk("ill_imm", imm, 32'd0);
      chk("ill_sel", 32'(sel), 32'd0);

      // addi x0,x0,7 sets nothing; add x9,x0,x0 must not stall
      typ = 3'd0; inst = 32'h0070_0013;
      step();
      chk("x0_we", 32'(we), 32'd0);
      typ = 3'd2; inst = 32'h0000_04B3;
      #1 chk("x0_ready", 32'(in_ready), 32'd1);
      step();

      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 199) == 0);
         inst_valid = ($urandom_range(0, 3) != 0);
         typ        = 3'($urandom_range(0, 7));
         inst       = $urandom;
         inst[19:15] = 5'($urandom_range(0, 7));
         inst[24:20] = 5'($urandom_range(0, 7));
         inst[11:7]  = 5'($urandom_range(0, 7));
         out_ready  = ($urandom_range(0, 9) < 7);
         wb_valid   = ($urandom_range(0, 9) < 4);
         wb_addr    = 5'($urandom_range(0, 7));
         step();
      end

      // Scoreboard-disabled instance: dependent add goes straight through
      reset = 1; inst_valid = 0; wb_valid = 0; out_ready = 1;
      step();
      reset = 0;
      typ = 3'd0; inst = 32'h0070_8293; inst_valid = 1;
      step();
      typ = 3'd2; inst = 32'h0022_8333;
      #1 chk("ns_add_ready", 32'(ns_in_ready), 32'd1);
      step();
      chk("ns_add_ov", 32'(ns_out_valid), 32'd1);
      chk("ns_add_a1", 32'(ns_a1), 32'd5);
      chk("ns_add_a3", 32'(ns_a3), 32'd6);

      // Reset with a result held: dropped, and no residual stall
      reset = 1; out_ready = 0; inst_valid = 0;
      step();
      reset = 0; out_ready = 1;
      chk("ns_rst_ov", 32'(ns_out_valid), 32'd0);
      chk("rst2_ov", 32'(out_valid), 32'd0);
      typ = 3'd2; inst = 32'h0022_8333; inst_valid = 1;
      #1 chk("rst2_no_stall", 32'(in_ready), 32'd1);
      step();
      inst_valid = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
